axi3_rd_arbiter: RTL and testbench
==================================

// Module: axi3_rd_arbiter
// PURPOSE
//  N-to-1 arbiter for the AXI3 read path (AR + R channels). Shares one AXI3 read master port
//  among N requesters, round-robin, one burst in flight at a time. Sits between DMA/CPU
//  read masters and a single axi3_if slave (e.g. DDR/PS port). Checks RLAST against ARLEN.
// PARAMETERS
//  N  = 2   number of requesters (2..8)
//  AW = 32  address width
//  DW = 32  data width
//  IW = 1   ID width (passed through unchanged)
// PORTS
//  ACLK        in   1      clock, all logic rising-edge
//  ARESETn     in   1      asynchronous active-low reset
//  s_arid      in   N*IW   per-requester ARID, requester i at [i*IW +: IW]
//  s_araddr    in   N*AW   per-requester ARADDR
//  s_arlen     in   N*8    per-requester ARLEN
//  s_arsize    in   N*3    per-requester ARSIZE
//  s_arburst   in   N*2    per-requester ARBURST
//  s_arprot    in   N*3    per-requester ARPROT
//  s_arvalid   in   N      per-requester ARVALID
//  s_arready   out  N      per-requester ARREADY
//  s_rid       out  IW     RID broadcast to all requesters
//  s_rdata     out  DW     RDATA broadcast
//  s_rresp     out  2      RRESP broadcast
//  s_rlast     out  1      RLAST broadcast
//  s_rvalid    out  N      RVALID, only granted bit may be 1
//  s_rready    in   N      per-requester RREADY
//  m_ar{id,addr,len,size,burst,prot,valid} out / m_arready in   AR master port
//  m_r{id,data,resp,last,valid} in / m_rready out               R master port
//  err_rlast   out  1      1-cycle pulse: RLAST position mismatch vs ARLEN
//  gnt         out  N      one-hot current grant (0 in IDLE)
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, pointer=0, beat cnt=0; m_arvalid, m_rready, s_arready,
//    s_rvalid, err_rlast = 0. m_ar* payload = 0. Reset mid-burst abandons it silently.
//  - IDLE: if |s_arvalid, pick first requester at/after pointer (wrapping) with arvalid;
//    register gnt, go ADDR. Grant latency: m_arvalid rises cycle after s_arvalid seen.
//  - ADDR: m_ar* = mux(gnt) of s_ar* (combinational); m_arvalid = s_arvalid[g];
//    s_arready[g] = m_arready, others 0. On m_arvalid&&m_arready: latch len, cnt=0, go DATA.
//  - DATA: s_r* = m_r*; s_rvalid[g] = m_rvalid, others 0; m_rready = s_rready[g].
//    Each R handshake: cnt++. On handshake with m_rlast: go IDLE, pointer=(g+1) mod N, gnt=0.
//  - RLAST check: err_rlast pulses on handshake where (m_rlast != (cnt==len)). Beat with
//    cnt==len and no RLAST: pulse, stay in DATA until RLAST. cnt saturates at 255.
//  - No new AR accepted until burst RLAST handshake; s_arready to losers always 0.
//  - Requesters hold AR stable while valid (AXI rule); arbiter never drops grant in ADDR.
//  - Simultaneous requests: pointer order; pointer only advances on burst completion.
//  - m_rvalid outside DATA: m_rready=0, ignored (protocol error, not flagged).
// STRUCTURE
//  - axi3_pkg: burst_t enum (FIXED/INCR/WRAP), resp_t enum (OKAY/EXOKAY/SLVERR/DECERR),
//    AXI3 field width localparams (LEN_W=8, SIZE_W=3, PROT_W=3).
//  - Sub-module rr_arbiter #(N): req[N], ptr[$clog2(N)] -> one-hot gnt, combinational.
//  - State enum {IDLE, ADDR, DATA} local to this module; registers in one always_ff.
// TESTING
//  1. Single req0 ARLEN=3 addr 0x100 -> m_araddr=0x100 one cycle later, 4 beats to req0,
//     s_rvalid[1]=0 throughout, gnt back to 0 after RLAST, err_rlast never set.
//  2. req0,req1 assert same cycle, ARLEN=0 each -> order 0,1; repeat -> pointer gives 1... no,
//     pointer after 1 is 0: sequence 0,1,0,1 across four back-to-back rounds.
//  3. m_arready held low 5 cycles in ADDR -> m_arvalid and payload stable, gnt unchanged.
//  4. Slave RLAST on beat 2 of ARLEN=3 -> err_rlast pulse on that beat, return to IDLE.
//  5. s_rready[g] toggling 1/0 -> m_rready mirrors it, beat count exact, no lost data.
//  6. ARESETn low mid-DATA beat 1 -> all outputs 0 asynchronously; new request works after.

Source files
------------

// File: rtl/axi3_pkg.sv
// Shared AXI3 field widths and encodings for the read-path arbiter.
package axi3_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [BURST_W-1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } burst_t;

    typedef enum logic [RESP_W-1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping, wins.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int unsigned PW = $clog2(N);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr) + off) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi3_rd_arbiter.sv
// N-to-1 AXI3 read-path arbiter: round-robin AR grant, one burst in flight,
// R routed back to the granted requester with RLAST-vs-ARLEN checking.
module axi3_rd_arbiter
    import axi3_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [N*IW-1:0]       s_arid,
    input  logic [N*AW-1:0]       s_araddr,
    input  logic [N*LEN_W-1:0]    s_arlen,
    input  logic [N*SIZE_W-1:0]   s_arsize,
    input  logic [N*BURST_W-1:0]  s_arburst,
    input  logic [N*PROT_W-1:0]   s_arprot,
    input  logic [N-1:0]          s_arvalid,
    output logic [N-1:0]          s_arready,
    output logic [IW-1:0]         s_rid,
    output logic [DW-1:0]         s_rdata,
    output logic [RESP_W-1:0]     s_rresp,
    output logic                  s_rlast,
    output logic [N-1:0]          s_rvalid,
    input  logic [N-1:0]          s_rready,
    output logic [IW-1:0]         m_arid,
    output logic [AW-1:0]         m_araddr,
    output logic [LEN_W-1:0]      m_arlen,
    output logic [SIZE_W-1:0]     m_arsize,
    output logic [BURST_W-1:0]    m_arburst,
    output logic [PROT_W-1:0]     m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [IW-1:0]         m_rid,
    input  logic [DW-1:0]         m_rdata,
    input  logic [RESP_W-1:0]     m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  err_rlast,
    output logic [N-1:0]          gnt
);

    localparam int unsigned PW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d, arb_gnt;
    logic [PW-1:0]    ptr_q, ptr_d, gidx;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic             ar_hs, r_hs;

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .req (s_arvalid),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_q[i]) gidx = PW'(i);
        end
    end

    assign ar_hs = (state_q == StAddr) && s_arvalid[gidx] && m_arready;
    assign r_hs  = (state_q == StData) && m_rvalid && s_rready[gidx];
    assign gnt   = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|s_arvalid) begin
                    gnt_d   = arb_gnt;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (ar_hs) begin
                    len_d   = s_arlen[gidx*LEN_W +: LEN_W];
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (r_hs) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // Only RLAST ends the burst, even if ARLEN was overrun.
                    if (m_rlast) begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        ptr_d   = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arprot  = '0;
        m_arvalid = 1'b0;
        s_arready = '0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        err_rlast = 1'b0;
        unique case (state_q)
            StAddr: begin
                m_arid          = s_arid[gidx*IW +: IW];
                m_araddr        = s_araddr[gidx*AW +: AW];
                m_arlen         = s_arlen[gidx*LEN_W +: LEN_W];
                m_arsize        = s_arsize[gidx*SIZE_W +: SIZE_W];
                m_arburst       = s_arburst[gidx*BURST_W +: BURST_W];
                m_arprot        = s_arprot[gidx*PROT_W +: PROT_W];
                m_arvalid       = s_arvalid[gidx];
                s_arready[gidx] = m_arready;
            end
            StData: begin
                s_rid          = m_rid;
                s_rdata        = m_rdata;
                s_rresp        = m_rresp;
                s_rlast        = m_rlast;
                s_rvalid[gidx] = m_rvalid;
                m_rready       = s_rready[gidx];
                err_rlast      = r_hs && (m_rlast != (cnt_q == len_q));
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Directed bench for axi3_rd_arbiter (N=2): table of single-requester bursts
// plus hand-written sequences for arbitration order, AR stall and reset.
module tb_axi3_rd_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 1;

    logic            ACLK;
    logic            ARESETn;
    logic [N*IW-1:0] s_arid;
    logic [N*AW-1:0] s_araddr;
    logic [N*8-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N*2-1:0]  s_arburst;
    logic [N*3-1:0]  s_arprot;
    logic [N-1:0]    s_arvalid;
    logic [N-1:0]    s_arready;
    logic [IW-1:0]   s_rid;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [IW-1:0]   m_arid;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic [2:0]      m_arprot;
    logic            m_arvalid;
    logic            m_arready;
    logic [IW-1:0]   m_rid;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;
    logic            err_rlast;
    logic [N-1:0]    gnt;

    int checks = 0;
    int errors = 0;

    axi3_rd_arbiter #(.N(N), .AW(AW), .DW(DW), .IW(IW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .err_rlast (err_rlast),
        .gnt       (gnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int          r;
        logic [31:0] addr;
        logic [7:0]  len;
        int          last_beat;
        bit          toggle;
        int          exp_beats;
        int          exp_errs;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive point is 1 time unit after the rising edge; samples are taken 4 later.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arprot  = '0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
    endtask

    task automatic run_burst(input vec_t v, output int beats, output int errs);
        int  cyc;
        bit  done;
        int  other;
        other = 1 - v.r;
        beats = 0;
        errs  = 0;
        s_arid[v.r]               = v.r[0];
        s_araddr[v.r*32 +: 32]    = v.addr;
        s_arlen[v.r*8 +: 8]       = v.len;
        s_arburst[v.r*2 +: 2]     = 2'b01;
        s_arvalid[v.r]            = 1'b1;
        m_arready                 = 1'b1;
        #4;
        chk("ar_latency_idle", m_arvalid, 0);
        tick();
        #4;
        chk("m_arvalid", m_arvalid, 1);
        chk("m_araddr", m_araddr, v.addr);
        chk("m_arlen", m_arlen, v.len);
        chk("m_arid", m_arid, v.r[0]);
        chk("gnt_addr", gnt, (v.r == 0) ? 2'b01 : 2'b10);
        chk("s_arready_win", s_arready[v.r], 1);
        chk("s_arready_lose", s_arready[other], 0);
        tick();
        s_arvalid[v.r] = 1'b0;
        m_arready      = 1'b0;
        done = 0;
        cyc  = 0;
        while (!done && cyc < 40) begin
            m_rvalid       = 1'b1;
            m_rid          = v.r[0];
            m_rresp        = 2'b10;
            m_rdata        = v.addr + 32'(beats);
            m_rlast        = (beats == v.last_beat);
            s_rready[v.r]  = v.toggle ? (cyc[0] == 1'b0) : 1'b1;
            #4;
            chk("s_rvalid_win", s_rvalid[v.r], 1);
            chk("s_rvalid_lose", s_rvalid[other], 0);
            chk("m_rready_mirror", m_rready, s_rready[v.r]);
            chk("s_rdata", s_rdata, v.addr + 32'(beats));
            chk("s_rresp", s_rresp, 2'b10);
            if (err_rlast) errs++;
            if (s_rready[v.r]) begin
                beats++;
                if (m_rlast) done = 1;
            end
            tick();
            cyc++;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        if (!done) chk("burst_timeout", 0, 1);
        #4;
        chk("gnt_after_rlast", gnt, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int       beats;
        int       errs;
        int       w;
        logic [1:0] expg;

        vecs[0] = '{r: 0, addr: 32'h100,  len: 8'd3, last_beat: 3, toggle: 0, exp_beats: 4, exp_errs: 0};
        vecs[1] = '{r: 1, addr: 32'h2000, len: 8'd0, last_beat: 0, toggle: 0, exp_beats: 1, exp_errs: 0};
        vecs[2] = '{r: 0, addr: 32'h300,  len: 8'd3, last_beat: 2, toggle: 0, exp_beats: 3, exp_errs: 1};
        vecs[3] = '{r: 1, addr: 32'h400,  len: 8'd1, last_beat: 3, toggle: 0, exp_beats: 4, exp_errs: 2};
        vecs[4] = '{r: 0, addr: 32'h500,  len: 8'd3, last_beat: 3, toggle: 1, exp_beats: 4, exp_errs: 0};
        vecs[5] = '{r: 1, addr: 32'h600,  len: 8'd2, last_beat: 2, toggle: 1, exp_beats: 3, exp_errs: 0};

        clear_inputs();
        ARESETn = 1'b0;
        #13;
        chk("rst_gnt", gnt, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_s_arready", s_arready, 0);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_err", err_rlast, 0);
        chk("rst_m_araddr", m_araddr, 0);
        #4;
        ARESETn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], beats, errs);
            chk($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
            chk($sformatf("vec%0d_errs", i), errs, vecs[i].exp_errs);
        end

        // Both requesters contend continuously: pointer order must alternate 0,1,0,1.
        s_araddr[0 +: 32]  = 32'h1000;
        s_araddr[32 +: 32] = 32'h1100;
        s_arlen            = '0;
        s_arid             = 2'b10;
        s_arvalid          = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expg = (k % 2 == 0) ? 2'b01 : 2'b10;
            w = 0;
            #4;
            while (!m_arvalid && w < 5) begin
                tick();
                #4;
                w++;
            end
            chk("rr_order", gnt, expg);
            chk("rr_addr", m_araddr, (k % 2 == 0) ? 32'h1000 : 32'h1100);
            chk("rr_lose_arready", s_arready & ~expg, 0);
            m_arready = 1'b1;
            tick();
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rlast   = 1'b1;
            s_rready  = 2'b11;
            #4;
            chk("rr_rvalid", s_rvalid, expg);
            chk("rr_err", err_rlast, 0);
            tick();
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            s_rready = '0;
        end
        s_arvalid = '0;
        tick();

        // AR stall: payload and grant hold while m_arready is low.
        s_araddr[0 +: 32] = 32'h700;
        s_arlen[0 +: 8]   = 8'd0;
        s_arvalid[0]      = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            #4;
            chk("stall_arvalid", m_arvalid, 1);
            chk("stall_araddr", m_araddr, 32'h700);
            chk("stall_gnt", gnt, 2'b01);
            tick();
        end
        m_arready = 1'b1;
        tick();
        m_arready    = 1'b0;
        s_arvalid[0] = 1'b0;
        m_rvalid     = 1'b1;
        m_rlast      = 1'b1;
        s_rready[0]  = 1'b1;
        #4;
        chk("stall_rvalid", s_rvalid, 2'b01);
        chk("stall_err", err_rlast, 0);
        tick();
        clear_inputs();
        #4;
        chk("stall_gnt_idle", gnt, 0);
        tick();

        // Asynchronous reset in the middle of a burst, then a fresh request.
        s_araddr[32 +: 32] = 32'h800;
        s_arlen[8 +: 8]    = 8'd3;
        s_arvalid[1]       = 1'b1;
        m_arready          = 1'b1;
        tick();
        tick();
        s_arvalid[1] = 1'b0;
        m_arready    = 1'b0;
        m_rvalid     = 1'b1;
        s_rready[1]  = 1'b1;
        m_rdata      = 32'h800;
        tick();
        #2;
        ARESETn = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_s_rvalid", s_rvalid, 0);
        chk("arst_m_rready", m_rready, 0);
        chk("arst_s_rdata", s_rdata, 0);
        chk("arst_m_arvalid", m_arvalid, 0);
        chk("arst_err", err_rlast, 0);
        clear_inputs();
        #3;
        ARESETn = 1'b1;
        tick();
        vecs[0] = '{r: 0, addr: 32'h900, len: 8'd1, last_beat: 1, toggle: 0, exp_beats: 2, exp_errs: 0};
        run_burst(vecs[0], beats, errs);
        chk("post_rst_beats", beats, 2);
        chk("post_rst_errs", errs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
